dmem_responder: RTL and testbench

//  Data-memory responder for the CPU's MA-stage load/store interface. Accepts one

---
 rtl/dmem_responder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the CPU's MA-stage load/store port. Accepts one
// request at a time, holds busywait high for exactly LATENCY cycles, then
// spends one DONE cycle with busywait low so the CPU can advance.
//
// Memory is a byte array of 2**ADDR_WIDTH entries, little-endian. Address bits
// above ADDR_WIDTH are ignored, so the array aliases across the 32-bit space.
//
// Loads:  funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Codes 011/110/111
//         behave as LW.
// Stores: 00 SB, 01 SH, 10 SW. Code 11 is a reserved no-op that still takes
//         the full latency.
// If a load and a store arrive together, only the store is performed and
// readdata keeps its old value.
//
// Optional feature: define DMEM_MISALIGN_TRAP_EN to add the 'misaligned'
// output. With it, a misaligned half or word access skips the BUSY phase,
// goes straight to DONE with misaligned=1 for that cycle, and has no effect.
// Without it, the low address bits are forced to the natural alignment and
// the access proceeds.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  read,
    input  logic [2:0]  write,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // The counter only has to hold LATENCY-1. Keep at least one bit so that
    // LATENCY=1 still elaborates.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Access size after decoding. SZ_NONE covers the reserved store code and
    // the no-request case.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_NONE = 2'd3;

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [3:0]            lat_read;
    logic [2:0]            lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_wdata;

    logic [7:0]            mem [DEPTH];

    // ------------------------------------------------------------------
    // Operand selection and decode
    // ------------------------------------------------------------------
    logic                  req;
    logic [3:0]            op_read;
    logic [2:0]            op_write;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [31:0]           op_wdata;
    logic                  op_store;
    logic                  op_load;
    logic                  op_unsigned;
    logic [1:0]            acc_size;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [3:0]            byte_en;
    logic                  op_misaligned;
    logic                  trap_now;
    logic                  perform;
    logic                  do_store;
    logic                  do_load;
    logic [7:0]            lane_b0;
    logic [7:0]            lane_b1;
    logic [7:0]            lane_b2;
    logic [7:0]            lane_b3;
    logic [31:0]           load_val;

    assign req = read[3] | write[2];

    // In IDLE, use the live inputs so that a LATENCY=1 access can complete on
    // its first edge. Otherwise use the copy taken when the request was accepted.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first, so no path can leave it unassigned and infer a latch.
        op_read  = lat_read;
        op_write = lat_write;
        op_addr  = lat_addr;
        op_wdata = lat_wdata;
        if (state == ST_IDLE) begin
            op_read  = read;
            op_write = write;
            op_addr  = address[ADDR_WIDTH-1:0];
            op_wdata = writedata;
        end
    end

    // Decode the operation into a size, an aligned base address and byte lanes.
    // A store takes priority over a simultaneous load.
    always_comb begin
        op_store    = op_write[2];
        op_load     = op_read[3] & ~op_write[2];
        op_unsigned = op_read[2] & ~op_read[1];
        acc_size    = SZ_NONE;
        if (op_store) begin
            acc_size = op_write[1:0];
        end else if (op_load) begin
            if (op_read[1]) begin
                acc_size = SZ_WORD;
            end else if (op_read[0]) begin
                acc_size = SZ_HALF;
            end else begin
                acc_size = SZ_BYTE;
            end
        end

        base_addr = op_addr;
        byte_en   = 4'b0000;
        case (acc_size)
            SZ_BYTE: byte_en = 4'b0001;
            SZ_HALF: begin
                base_addr = {op_addr[ADDR_WIDTH-1:1], 1'b0};
                byte_en   = 4'b0011;
            end
            SZ_WORD: begin
                base_addr = {op_addr[ADDR_WIDTH-1:2], 2'b00};
                byte_en   = 4'b1111;
            end
            default: byte_en = 4'b0000;
        endcase

        op_misaligned = ((acc_size == SZ_HALF) && op_addr[0]) ||
                        ((acc_size == SZ_WORD) && (op_addr[1:0] != 2'b00));
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap_now = (state == ST_IDLE) & req & op_misaligned;
`else
    // Without the trap, forcing the low address bits to alignment already
    // handles the misaligned case, so this flag has no effect.
    assign trap_now = 1'b0;
`endif

    // An access completes either on the accepting edge (LATENCY=1) or on the
    // last BUSY edge. Reset blocks it because the array itself has no reset.
    assign perform  = rst_n & ~trap_now &
                      (((state == ST_IDLE) & req & (LATENCY == 1)) |
                       ((state == ST_BUSY) & (cnt == CNT_W'(1))));
    assign do_store = perform & op_store & (acc_size != SZ_NONE);
    assign do_load  = perform & op_load;

    // Gather the four bytes at the base address and extend them to the load size.
    always_comb begin
        lane_b0  = mem[base_addr];
        lane_b1  = mem[base_addr + ADDR_WIDTH'(1)];
        lane_b2  = mem[base_addr + ADDR_WIDTH'(2)];
        lane_b3  = mem[base_addr + ADDR_WIDTH'(3)];
        load_val = {lane_b3, lane_b2, lane_b1, lane_b0};
        case (acc_size)
            SZ_BYTE: load_val = op_unsigned ? {24'h0, lane_b0}
                                            : {{24{lane_b0[7]}}, lane_b0};
            SZ_HALF: load_val = op_unsigned ? {16'h0, lane_b1, lane_b0}
                                            : {{16{lane_b1[7]}}, lane_b1, lane_b0};
            default: load_val = {lane_b3, lane_b2, lane_b1, lane_b0};
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: accept in IDLE, count down in BUSY, one DONE cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments, so every
        // clocked block reads the pre-edge values regardless of block order.
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_read  <= '0;
            lat_write <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        lat_read  <= read;
                        lat_write <= write;
                        lat_addr  <= address[ADDR_WIDTH-1:0];
                        lat_wdata <= writedata;
                        if (trap_now || (LATENCY == 1)) begin
                            state <= ST_DONE;
                        end else begin
                            cnt   <= CNT_W'(LATENCY - 1);
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Load result register: keeps its value until the next load completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readdata <= '0;
        end else if (do_load) begin
            readdata <= load_val;
        end
    end

    // Byte-lane write into the array.
    always_ff @(posedge clk) begin
        // NOTE: the storage array deliberately has no reset. Contents survive
        // rst_n, and a reset port would prevent mapping onto RAM.
        if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[base_addr + ADDR_WIDTH'(i)] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // The trap flag is set on the IDLE->DONE edge of a trapped request and is
    // therefore high only during that DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= trap_now;
        end
    end
`endif

    // Stall the CPU while a request is presented in IDLE and throughout BUSY.
    always_comb begin
        busywait = 1'b0;
        case (state)
            ST_IDLE: busywait = req;
            ST_BUSY: busywait = 1'b1;
            default: busywait = 1'b0;
        endcase
        busywait = busywait & rst_n;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Bench for dmem_responder. It drives a default instance (LATENCY=4) and a
// LATENCY=1 instance. Expected values come from a byte-array reference model
// and from hand-derived constants. Define DMEM_MISALIGN_TRAP_EN to build the
// trap variant.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int AW    = 10;
    localparam int LAT   = 4;
    localparam int DEPTH = 2 ** AW;

    localparam logic [3:0] NOR = 4'b0000;
    localparam logic [3:0] LB  = 4'b1000;
    localparam logic [3:0] LH  = 4'b1001;
    localparam logic [3:0] LW  = 4'b1010;
    localparam logic [3:0] LBU = 4'b1100;
    localparam logic [3:0] LHU = 4'b1101;
    localparam logic [2:0] NOW = 3'b000;
    localparam logic [2:0] SB  = 3'b100;
    localparam logic [2:0] SH  = 3'b101;
    localparam logic [2:0] SW  = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [3:0]  read0, read1;
    logic [2:0]  write0, write1;
    logic [31:0] address0, address1;
    logic [31:0] writedata0, writedata1;
    logic [31:0] readdata0, readdata1;
    logic        busywait0, busywait1;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        misaligned0, misaligned1;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .read      (read0),
        .write     (write0),
        .address   (address0),
        .writedata (writedata0),
        .readdata  (readdata0),
        .busywait  (busywait0)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .misaligned(misaligned0)
`endif
    );

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut_l1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .read      (read1),
        .write     (write1),
        .address   (address1),
        .writedata (writedata1),
        .readdata  (readdata1),
        .busywait  (busywait1)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .misaligned(misaligned1)
`endif
    );

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] ref_rd = 32'h0;

    // Applies one access to the byte-array model and returns the expected
    // busywait length and trap flag.
    task automatic ref_apply(input logic [3:0] rd, input logic [2:0] wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output int exp_busy, output logic exp_mis);
        int a, nb, base;
        bit sgn, mis;
        logic [31:0] v;
        a   = int'(addr % 32'(DEPTH));
        nb  = 0;
        sgn = 1'b0;
        if (wr[2]) begin
            case (wr[1:0])
                2'd0:    nb = 1;
                2'd1:    nb = 2;
                2'd2:    nb = 4;
                default: nb = 0;
            endcase
        end else if (rd[3]) begin
            case (rd[2:0])
                3'd0:    begin nb = 1; sgn = 1'b1; end
                3'd1:    begin nb = 2; sgn = 1'b1; end
                3'd4:    nb = 1;
                3'd5:    nb = 2;
                default: nb = 4;
            endcase
        end
        mis      = (nb == 2 && a % 2 != 0) || (nb == 4 && a % 4 != 0);
        exp_busy = LAT;
        exp_mis  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (mis) begin
            exp_busy = 1;
            exp_mis  = 1'b1;
            return;
        end
`endif
        base = (nb == 0) ? a : a - a % nb;
        if (wr[2]) begin
            for (int i = 0; i < nb; i++) ref_mem[base + i] = wdata[8*i +: 8];
        end else if (rd[3]) begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
            if (sgn && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            ref_rd = v;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [3:0] rd, input logic [2:0] wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            read1 = rd; write1 = wr; address1 = addr; writedata1 = wdata;
        end else begin
            read0 = rd; write0 = wr; address0 = addr; writedata0 = wdata;
        end
    endtask

    // Presents a request starting just after a rising edge. It counts the
    // cycles with busywait high, samples the DONE cycle, and returns to idle.
    // With swap set, the address changes after the accepting edge.
    task automatic access(input bit sel, input logic [3:0] rd, input logic [2:0] wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit swap, input logic [31:0] alt_addr,
                          output int busy, output logic [31:0] rdata, output logic mis);
        bit done;
        drive(sel, rd, wr, addr, wdata);
        busy  = 0;
        rdata = 32'h0;
        mis   = 1'b0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (sel ? busywait1 : busywait0) begin
                busy++;
            end else begin
                rdata = sel ? readdata1 : readdata0;
`ifdef DMEM_MISALIGN_TRAP_EN
                mis   = sel ? misaligned1 : misaligned0;
`endif
                done  = 1'b1;
            end
            if (swap && c == 0 && !done) begin
                @(posedge clk);
                #1;
                drive(sel, rd, wr, alt_addr, ~wdata);
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL access timeout: busywait still high after 40 cycles, expected DONE");
        end
        @(posedge clk);
        #1;
        drive(sel, NOR, NOW, 32'h0, 32'h0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [20];

    initial begin
        int          busy, eb;
        logic [31:0] rdata;
        logic        mis, em;
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr, wdata;
        int          k;

        drive(0, NOR, NOW, 32'h0, 32'h0);
        drive(1, NOR, NOW, 32'h0, 32'h0);

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset busywait", 32'(busywait0), 32'h0);
        check("reset readdata", readdata0, 32'h0);
        check("reset readdata l1", readdata1, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Give every word a known value
        for (int w = 0; w < DEPTH / 4; w++) begin
            wdata = $urandom();
            access(0, NOR, SW, 32'(w * 4), wdata, 1'b0, 32'h0, busy, rdata, mis);
            ref_apply(NOR, SW, 32'(w * 4), wdata, eb, em);
        end

        tbl[0]  = '{NOR, SW,     32'h010, 32'hDEADBEEF, 32'h00000000};
        tbl[1]  = '{LW,  NOW,    32'h010, 32'h0,        32'hDEADBEEF};
        tbl[2]  = '{NOR, SB,     32'h013, 32'h12345680, 32'hDEADBEEF};
        tbl[3]  = '{LB,  NOW,    32'h013, 32'h0,        32'hFFFFFF80};
        tbl[4]  = '{LBU, NOW,    32'h013, 32'h0,        32'h00000080};
        tbl[5]  = '{LW,  NOW,    32'h010, 32'h0,        32'h80ADBEEF};
        tbl[6]  = '{NOR, SH,     32'h022, 32'hABCD8001, 32'h80ADBEEF};
        tbl[7]  = '{LH,  NOW,    32'h022, 32'h0,        32'hFFFF8001};
        tbl[8]  = '{LHU, NOW,    32'h022, 32'h0,        32'h00008001};
        tbl[9]  = '{LW,  SW,     32'h024, 32'h12345678, 32'h00008001};
        tbl[10] = '{LW,  NOW,    32'h024, 32'h0,        32'h12345678};
        tbl[11] = '{LW,  NOW,    32'h410, 32'h0,        32'h80ADBEEF};
        tbl[12] = '{NOR, SW,     32'h414, 32'hCAFEF00D, 32'h80ADBEEF};
        tbl[13] = '{LW,  NOW,    32'h014, 32'h0,        32'hCAFEF00D};
        tbl[14] = '{4'b1011, NOW, 32'h024, 32'h0,       32'h12345678};
        tbl[15] = '{LH,  NOW,    32'h010, 32'h0,        32'hFFFFBEEF};
        tbl[16] = '{LB,  NOW,    32'h011, 32'h0,        32'hFFFFFFBE};
        tbl[17] = '{LBU, NOW,    32'h012, 32'h0,        32'h000000AD};
        tbl[18] = '{4'b1110, NOW, 32'h010, 32'h0,       32'h80ADBEEF};
        tbl[19] = '{NOR, 3'b111, 32'h010, 32'h0,        32'h80ADBEEF};

        for (int i = 0; i < 20; i++) begin
            access(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, 32'h0, busy, rdata, mis);
            ref_apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, eb, em);
            check($sformatf("tbl[%0d] busy cycles", i), 32'(busy), 32'(LAT));
            check($sformatf("tbl[%0d] readdata", i), rdata, tbl[i].exp_rd);
        end
        // The reserved store code must leave memory untouched
        access(0, LW, NOW, 32'h010, 32'h0, 1'b0, 32'h0, busy, rdata, mis);
        ref_apply(LW, NOW, 32'h010, 32'h0, eb, em);
        check("reserved store no-op", rdata, 32'h80ADBEEF);

        // Address change during BUSY is ignored
        access(0, LW, NOW, 32'h010, 32'h0, 1'b1, 32'h014, busy, rdata, mis);
        ref_apply(LW, NOW, 32'h010, 32'h0, eb, em);
        check("addr change in busy", rdata, 32'h80ADBEEF);

        // Misaligned word load
        access(0, LW, NOW, 32'h014, 32'h0, 1'b0, 32'h0, busy, rdata, mis);
        ref_apply(LW, NOW, 32'h014, 32'h0, eb, em);
        check("pre-misalign load", rdata, 32'hCAFEF00D);
        access(0, LW, NOW, 32'h011, 32'h0, 1'b0, 32'h0, busy, rdata, mis);
        ref_apply(LW, NOW, 32'h011, 32'h0, eb, em);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("misaligned LW busy", 32'(busy), 32'd1);
        check("misaligned LW flag", 32'(mis), 32'd1);
        check("misaligned LW readdata held", rdata, 32'hCAFEF00D);
        access(0, NOR, SW, 32'h012, 32'h0, 1'b0, 32'h0, busy, rdata, mis);
        ref_apply(NOR, SW, 32'h012, 32'h0, eb, em);
        check("misaligned SW busy", 32'(busy), 32'd1);
        check("misaligned SW flag", 32'(mis), 32'd1);
        access(0, LW, NOW, 32'h010, 32'h0, 1'b0, 32'h0, busy, rdata, mis);
        ref_apply(LW, NOW, 32'h010, 32'h0, eb, em);
        check("misaligned SW suppressed", rdata, 32'h80ADBEEF);
        check("flag clear after DONE", 32'(mis), 32'd0);
`else
        check("misaligned LW busy", 32'(busy), 32'(LAT));
        check("misaligned LW forced aligned", rdata, 32'h80ADBEEF);
`endif

        // Randomised traffic against the model
        for (int n = 0; n < 300; n++) begin
            k  = $urandom_range(0, 9);
            rd = NOR;
            wr = NOW;
            if (k < 4) begin
                rd = {1'b1, 3'($urandom_range(0, 7))};
            end else if (k < 8) begin
                wr = {1'b1, 2'($urandom_range(0, 2))};
            end else if (k == 8) begin
                rd = {1'b1, 3'($urandom_range(0, 7))};
                wr = {1'b1, 2'($urandom_range(0, 2))};
            end else begin
                wr = 3'b111;
            end
            addr  = $urandom();
            wdata = $urandom();
            access(0, rd, wr, addr, wdata, 1'b0, 32'h0, busy, rdata, mis);
            ref_apply(rd, wr, addr, wdata, eb, em);
            check($sformatf("rand[%0d] busy r=%h w=%h a=%h", n, rd, wr, addr), 32'(busy), 32'(eb));
            check($sformatf("rand[%0d] readdata r=%h w=%h a=%h", n, rd, wr, addr), rdata, ref_rd);
`ifdef DMEM_MISALIGN_TRAP_EN
            check($sformatf("rand[%0d] misaligned", n), 32'(mis), 32'(em));
`endif
        end

        // Reset in the middle of a store: store dropped, outputs cleared at once
        drive(0, NOR, SW, 32'h040, 32'h55AA55AA);
        @(negedge clk);
        @(negedge clk);
        check("busy before reset", 32'(busywait0), 32'h1);
        rst_n = 1'b0;
        #1;
        check("busywait in reset", 32'(busywait0), 32'h0);
        check("readdata in reset", readdata0, 32'h0);
        drive(0, NOR, NOW, 32'h0, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ref_rd = 32'h0;
        access(0, LW, NOW, 32'h040, 32'h0, 1'b0, 32'h0, busy, rdata, mis);
        ref_apply(LW, NOW, 32'h040, 32'h0, eb, em);
        check("post-reset busy", 32'(busy), 32'(LAT));
        check("post-reset LW pre-store value", rdata, ref_rd);

        // LATENCY=1 instance
        access(1, NOR, SW, 32'h030, 32'hA5A55A5A, 1'b0, 32'h0, busy, rdata, mis);
        check("l1 SW busy", 32'(busy), 32'd1);
        check("l1 SW readdata", rdata, 32'h0);
        access(1, LW, NOW, 32'h430, 32'h0, 1'b0, 32'h0, busy, rdata, mis);
        check("l1 LW busy", 32'(busy), 32'd1);
        check("l1 LW alias readdata", rdata, 32'hA5A55A5A);
        access(1, LHU, NOW, 32'h032, 32'h0, 1'b0, 32'h0, busy, rdata, mis);
        check("l1 LHU readdata", rdata, 32'h0000A5A5);
        access(1, NOR, SB, 32'h031, 32'hFFFFFF7F, 1'b0, 32'h0, busy, rdata, mis);
        access(1, LB, NOW, 32'h031, 32'h0, 1'b0, 32'h0, busy, rdata, mis);
        check("l1 LB positive", rdata, 32'h0000007F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
